// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: default character width and the tx-drain FSM encoding.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer push side plus uart_tx launch handshake; ovf_clr/overflow exist only with UART_TX_FIFO_OVF_EN.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              uart_tx_en;
  logic [DATA_W-1:0] uart_tx_data;
  logic              tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic              overflow;
  logic              ovf_clr;
`endif

  modport slave (
`ifdef UART_TX_FIFO_OVF_EN
    output overflow,
    input  ovf_clr,
`endif
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, uart_tx_en, uart_tx_data
  );

  modport master (
`ifdef UART_TX_FIFO_OVF_EN
    input  overflow,
    output ovf_clr,
`endif
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset on the array.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx; a push into an empty FIFO launches uart_tx_en one edge after it is stored.
// Pushes while full are dropped (sticky overflow flag when UART_TX_FIFO_OVF_EN is defined); drain waits on tx_busy.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  tx_state_t         state, state_nxt;
  logic              tx_en_q, tx_en_nxt;
  logic [DATA_W-1:0] tx_data_q, tx_data_nxt, rd_data;
  logic              full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO rejects the push even when a pop frees a slot this cycle.
  assign push  = bus.wr_en && !full;

  uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt   = state;
    tx_en_nxt   = tx_en_q;
    tx_data_nxt = tx_data_q;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop         = 1'b1;
          tx_data_nxt = rd_data;
          tx_en_nxt   = 1'b1;
          state_nxt   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          tx_en_nxt = 1'b0;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_nxt = ST_IDLE;
      end
      default: begin
        tx_en_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_nxt = push ? wr_ptr + ADDR_W'(1) : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + ADDR_W'(1) : rd_ptr;
    count_nxt  = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count_q   <= count_nxt;
      tx_en_q   <= tx_en_nxt;
      tx_data_q <= tx_data_nxt;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // A dropped push outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                    ovf_q <= 1'b0;
    else if (bus.wr_en && full) ovf_q <= 1'b1;
    else if (bus.ovf_clr)       ovf_q <= 1'b0;
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.uart_tx_en   = tx_en_q;
  assign bus.uart_tx_data = tx_data_q;
endmodule
